// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between execute stage and word-organised data memory
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake (ready only while idle)
//   req_we, req_funct3                store flag, RV32I access size/signedness
//   req_addr, req_wdata               byte address, LSB-aligned store data
//   rsp_valid, rsp_rdata, rsp_err     one-cycle response pulse with extended load data / error
//   mem_addr, mem_wdata               word address and lane-positioned write data
//   mem_wmask, mem_wen                byte-lane enables, write strobe
//   mem_rdata                         combinational read data for mem_addr

module lsu_ctrl #(
    parameter int unsigned MEM_BYTES        = 4096,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [3:0]  hi_mask_q, hi_mask_d;
    logic [31:0] hi_wdata_q, hi_wdata_d;
    logic [31:0] next_word_q, next_word_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] mem_addr_q, mem_wdata_q;

    // Request decode
    logic        accept;
    logic [1:0]  off;
    logic [2:0]  size;
    logic [3:0]  size_mask;
    logic [3:0]  off_end;
    logic        legal_f3;
    logic        crossing;
    logic        misaligned;
    logic        out_of_range;
    logic        err_now;
    logic [32:0] last_byte;
    logic [7:0]  lane8;
    logic [63:0] wd64;
    logic [5:0]  hi_shamt;
    logic [31:0] ext_data;

    always_comb begin
        // Reset is folded in so a request held high during reset never strobes memory.
        accept = req_valid && (state_q == IDLE) && rst_n;
        off    = req_addr[1:0];
        unique case (req_funct3[1:0])
            2'd0:    begin size = 3'd1; size_mask = 4'b0001; end
            2'd1:    begin size = 3'd2; size_mask = 4'b0011; end
            default: begin size = 3'd4; size_mask = 4'b1111; end
        endcase
        if (req_we) legal_f3 = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
        else        legal_f3 = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2)
                            || (req_funct3 == 3'd4) || (req_funct3 == 3'd5);
        off_end      = {2'b00, off} + {1'b0, size};
        crossing     = off_end > 4'd4;
        misaligned   = ((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'd0));
        // 33-bit sum so an access running past 0xFFFFFFFF is caught rather than wrapping to 0
        last_byte    = {1'b0, req_addr} + {30'b0, size} - 33'd1;
        out_of_range = last_byte >= 33'(MEM_BYTES);
        err_now      = !legal_f3 || (!ALLOW_MISALIGNED && misaligned) || out_of_range;
        // Lower nibble/word is the first memory cycle, upper is the spill into the next word
        lane8        = {4'b0000, size_mask} << off;
        wd64         = {32'b0, req_wdata} << {off, 3'b000};
        hi_shamt     = 6'd32 - {1'b0, off_q, 3'b000};
    end

    always_comb begin
        unique case (funct3_q)
            3'd0:    ext_data = {{24{buf_q[7]}}, buf_q[7:0]};
            3'd1:    ext_data = {{16{buf_q[15]}}, buf_q[15:0]};
            3'd2:    ext_data = buf_q;
            3'd4:    ext_data = {24'b0, buf_q[7:0]};
            3'd5:    ext_data = {16'b0, buf_q[15:0]};
            default: ext_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        err_d       = err_q;
        hi_mask_d   = hi_mask_q;
        hi_wdata_d  = hi_wdata_q;
        next_word_d = next_word_q;
        buf_d       = buf_q;
        req_ready   = (state_q == IDLE);
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = 32'h0;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        mem_wmask   = 4'b0000;
        mem_wen     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_addr    = {req_addr[31:2], 2'b00};
                    mem_wdata   = wd64[31:0];
                    mem_wmask   = lane8[3:0];
                    mem_wen     = req_we && !err_now;
                    off_d       = off;
                    funct3_d    = req_funct3;
                    we_d        = req_we;
                    err_d       = err_now;
                    hi_mask_d   = lane8[7:4];
                    hi_wdata_d  = wd64[63:32];
                    next_word_d = {req_addr[31:2], 2'b00} + 32'd4;
                    // Byte buffer holds the access LSB-first; lanes below off are shifted out
                    buf_d       = mem_rdata >> {off, 3'b000};
                    state_d     = (!err_now && crossing) ? SPLIT : RESP;
                end
            end
            SPLIT: begin
                mem_addr  = next_word_q;
                mem_wdata = hi_wdata_q;
                mem_wmask = hi_mask_q;
                mem_wen   = we_q;
                buf_d     = buf_q | (mem_rdata << hi_shamt);
                state_d   = RESP;
            end
            RESP: begin
                req_ready = 1'b0;
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? 32'h0 : ext_data;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            off_q       <= 2'd0;
            funct3_q    <= 3'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            hi_mask_q   <= 4'b0000;
            hi_wdata_q  <= 32'h0;
            next_word_q <= 32'h0;
            buf_q       <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            err_q       <= err_d;
            hi_mask_q   <= hi_mask_d;
            hi_wdata_q  <= hi_wdata_d;
            next_word_q <= next_word_d;
            buf_q       <= buf_d;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
        end
    end

endmodule
